// File: rtl/nco_pkg.sv
// Shared definitions for the rotating-NCO datapath: scheduler state
// encoding, bin-row width and the NCO settle constant used by the NCO,
// MAC and scheduler blocks.
package nco_pkg;

    localparam int VPOS_W     = 9;
    localparam int NCO_SETTLE = 6;
    localparam int CNT_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_ACCUM  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_RESULT = 3'd5
    } sched_state_e;

endpackage

// File: rtl/nco_bin_cnt.sv
// Loadable down-counter with terminal-count flag. One instance times the
// settle, accumulate and drain phases of each bin in turn.
module nco_bin_cnt
    import nco_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    // Count register: load wins, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= {W{1'b0}};
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != {W{1'b0}}) begin
            cnt <= cnt - W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign tc = (cnt == {W{1'b0}});

endmodule

// File: rtl/nco_bin_sched.sv
// Bin sequencer for the 4-phasor rotating NCO. Sweeps bin rows
// V_FIRST..V_LAST per frame: start pulse, NCO settle, N_SAMP accumulate
// cycles with read addresses, MAC drain, then a valid/ready result hand-off.
// Optional feature: define NCO_BIN_SCHED_PINGPONG_EN to add the BANK output
// (sample-buffer bank select, toggling at the end of every frame).
module nco_bin_sched
    import nco_pkg::*;
#(
    parameter int N_SAMP  = 512,
    parameter int AW      = 9,
    parameter int SETTLE  = NCO_SETTLE,
    parameter int ACC_LAT = 3,
    parameter int V_FIRST = 0,
    parameter int V_LAST  = 127
) (
    input  logic              CK,
    input  logic              RSTN,
    input  logic              FRAME_GO,
    output logic              NCO_START,
    output logic [VPOS_W-1:0] NCO_VPOS,
    output logic              ACC_CLR,
    output logic              ACC_EN,
    output logic [AW-1:0]     RD_ADDR,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [VPOS_W-1:0] RES_VPOS,
    output logic              BUSY,
    output logic              FRAME_DONE
`ifdef NCO_BIN_SCHED_PINGPONG_EN
    ,
    output logic              BANK
`endif
);

    localparam logic [VPOS_W-1:0] V_FIRST_V = VPOS_W'(V_FIRST);
    localparam logic [VPOS_W-1:0] V_LAST_V  = VPOS_W'(V_LAST);

    // Degenerate phase lengths skip the corresponding state entirely.
    localparam sched_state_e AFTER_START = (SETTLE > 1)  ? ST_SETTLE : ST_ACCUM;
    localparam sched_state_e AFTER_ACCUM = (ACC_LAT > 0) ? ST_DRAIN  : ST_RESULT;

    sched_state_e     state_r;
    sched_state_e     state_n;
    logic             accept_s;
    logic             last_s;
    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_load_val_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_tc_s;

    assign accept_s = (state_r == ST_RESULT) && RES_READY;
    assign last_s   = (NCO_VPOS == V_LAST_V);

    nco_bin_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (CK),
        .rst_n    (RSTN),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .cnt      (cnt_val_s),
        .tc       (cnt_tc_s)
    );

    // Next-state logic; FRAME_GO is ignored while the done pulse is out.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (FRAME_GO && !FRAME_DONE) state_n = ST_START;
                else                         state_n = ST_IDLE;
            end
            ST_START: begin
                state_n = AFTER_START;
            end
            ST_SETTLE: begin
                if (cnt_tc_s) state_n = ST_ACCUM;
                else          state_n = ST_SETTLE;
            end
            ST_ACCUM: begin
                if (cnt_tc_s) state_n = AFTER_ACCUM;
                else          state_n = ST_ACCUM;
            end
            ST_DRAIN: begin
                if (cnt_tc_s) state_n = ST_RESULT;
                else          state_n = ST_DRAIN;
            end
            ST_RESULT: begin
                if (accept_s && last_s) state_n = ST_IDLE;
                else if (accept_s)      state_n = ST_START;
                else                    state_n = ST_RESULT;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Phase counter reload on entry to each timed phase (length minus one).
    always_comb begin
        cnt_load_val_s = {CNT_W{1'b0}};
        case (state_n)
            ST_SETTLE: cnt_load_val_s = CNT_W'(SETTLE - 2);
            ST_ACCUM:  cnt_load_val_s = CNT_W'(N_SAMP - 1);
            ST_DRAIN:  cnt_load_val_s = CNT_W'(ACC_LAT - 1);
            default:   cnt_load_val_s = {CNT_W{1'b0}};
        endcase
        if (state_n != state_r) begin
            cnt_load_s = (state_n == ST_SETTLE) || (state_n == ST_ACCUM) ||
                         (state_n == ST_DRAIN);
        end else begin
            cnt_load_s = 1'b0;
        end
    end

    // State register and outputs registered from the next state.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_r    <= ST_IDLE;
            NCO_START  <= 1'b0;
            ACC_CLR    <= 1'b0;
            ACC_EN     <= 1'b0;
            RD_ADDR    <= {AW{1'b0}};
            RES_VALID  <= 1'b0;
            RES_VPOS   <= {VPOS_W{1'b0}};
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
        end else begin
            state_r    <= state_n;
            NCO_START  <= (state_n == ST_START);
            ACC_CLR    <= (state_n == ST_START);
            ACC_EN     <= (state_n == ST_ACCUM);
            RES_VALID  <= (state_n == ST_RESULT);
            BUSY       <= (state_n != ST_IDLE);
            FRAME_DONE <= accept_s && last_s;
            if ((state_r == ST_ACCUM) && (state_n == ST_ACCUM)) begin
                RD_ADDR <= RD_ADDR + AW'(1);
            end else begin
                RD_ADDR <= {AW{1'b0}};
            end
            if (state_n == ST_RESULT) begin
                RES_VPOS <= NCO_VPOS;
            end else begin
                RES_VPOS <= {VPOS_W{1'b0}};
            end
        end
    end

    // Bin row advances only on result acceptance, so it is stable through ACCUM.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            NCO_VPOS <= V_FIRST_V;
        end else if (accept_s && last_s) begin
            NCO_VPOS <= V_FIRST_V;
        end else if (accept_s) begin
            NCO_VPOS <= NCO_VPOS + VPOS_W'(1);
        end else begin
            NCO_VPOS <= NCO_VPOS;
        end
    end

`ifdef NCO_BIN_SCHED_PINGPONG_EN
    // Bank select flips together with the frame-done pulse.
    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            BANK <= 1'b0;
        end else if (accept_s && last_s) begin
            BANK <= ~BANK;
        end else begin
            BANK <= BANK;
        end
    end
`endif

endmodule
